// File: rtl/pipe_accum_cpu.sv
// Three-stage (fetch / decode / execute) accumulator CPU with A, B, OUT and a carry flag.
// Taken jumps resolve in EX and squash the two younger instructions behind them.
module pipe_accum_cpu #(
  parameter int DW = 4,
  parameter int AW = 4
) (
  input  logic            CK,
  input  logic            RST_N,
  output logic [AW-1:0]   IMEM_AD,
  input  logic [DW+3:0]   IMEM_Q,
  input  logic [DW-1:0]   IN_D,
  output logic [DW-1:0]   OUT_Q,
  output logic            OUT_VLD,
  output logic            CFLAG
);

  typedef enum logic [1:0] {
    SEL_A    = 2'd0,
    SEL_B    = 2'd1,
    SEL_IN   = 2'd2,
    SEL_ZERO = 2'd3
  } sel_t;

  typedef struct packed {
    logic ld_a;
    logic ld_b;
    logic ld_o;
    logic jmp;
    logic jnc;
    sel_t sel;
  } ctrl_t;

  logic [AW-1:0] pc;
  logic          ifid_valid;
  logic [DW+3:0] ifid_instr;
  logic          idex_valid;
  ctrl_t         idex_ctrl;
  logic [DW-1:0] idex_im;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic [DW-1:0] out_q;
  logic          c_q;
  logic          out_vld;

  ctrl_t         dec;
  logic [DW-1:0] y;
  logic [DW:0]   sum_full;
  logic          take;

  always_comb begin
    dec = '{ld_a: 1'b0, ld_b: 1'b0, ld_o: 1'b0, jmp: 1'b0, jnc: 1'b0, sel: SEL_ZERO};
    case (ifid_instr[DW+3:DW])
      4'b0000: begin dec.ld_a = 1'b1; dec.sel = SEL_A;    end
      4'b0001: begin dec.ld_a = 1'b1; dec.sel = SEL_B;    end
      4'b0010: begin dec.ld_a = 1'b1; dec.sel = SEL_IN;   end
      4'b0011: begin dec.ld_a = 1'b1; dec.sel = SEL_ZERO; end
      4'b0100: begin dec.ld_b = 1'b1; dec.sel = SEL_A;    end
      4'b0101: begin dec.ld_b = 1'b1; dec.sel = SEL_B;    end
      4'b0110: begin dec.ld_b = 1'b1; dec.sel = SEL_IN;   end
      4'b0111: begin dec.ld_b = 1'b1; dec.sel = SEL_ZERO; end
      4'b1001: begin dec.ld_o = 1'b1; dec.sel = SEL_B;    end
      4'b1011: begin dec.ld_o = 1'b1; dec.sel = SEL_ZERO; end
      4'b1110: dec.jnc = 1'b1;
      4'b1111: dec.jmp = 1'b1;
      default: ;
    endcase
  end

  // Operands are read here in EX, so no forwarding is needed for back-to-back use.
  always_comb begin
    y = '0;
    case (idex_ctrl.sel)
      SEL_A:    y = a_q;
      SEL_B:    y = b_q;
      SEL_IN:   y = IN_D;
      default:  y = '0;
    endcase
  end

  assign sum_full = {1'b0, y} + {1'b0, idex_im};
  // JNC looks at the carry as it stood before this instruction's own update.
  assign take = idex_valid & (idex_ctrl.jmp | (idex_ctrl.jnc & ~c_q));

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      pc         <= '0;
      ifid_valid <= 1'b0;
      ifid_instr <= '0;
      idex_valid <= 1'b0;
      idex_ctrl  <= '{ld_a: 1'b0, ld_b: 1'b0, ld_o: 1'b0, jmp: 1'b0, jnc: 1'b0, sel: SEL_ZERO};
      idex_im    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      out_q      <= '0;
      c_q        <= 1'b0;
      out_vld    <= 1'b0;
    end else begin
      pc         <= take ? idex_im[AW-1:0] : pc + AW'(1);
      ifid_valid <= ~take;
      ifid_instr <= IMEM_Q;
      idex_valid <= ifid_valid & ~take;
      idex_ctrl  <= dec;
      idex_im    <= ifid_instr[DW-1:0];
      out_vld    <= idex_valid & idex_ctrl.ld_o;
      if (idex_valid) begin
        c_q <= sum_full[DW];
        if (idex_ctrl.ld_a) a_q   <= sum_full[DW-1:0];
        if (idex_ctrl.ld_b) b_q   <= sum_full[DW-1:0];
        if (idex_ctrl.ld_o) out_q <= sum_full[DW-1:0];
      end
    end
  end

  assign IMEM_AD = pc;
  assign OUT_Q   = out_q;
  assign OUT_VLD = out_vld;
  assign CFLAG   = c_q;

endmodule

// File: tb/tb_pipe_accum_cpu.sv
// Directed bench for pipe_accum_cpu: a 4/4 instance and an 8/6 instance, each fed by
// a behavioural ROM; OUT_Q values are checked against an expected queue as OUT_VLD pulses.
module tb_pipe_accum_cpu;

  logic        ck;
  logic        rst0_n;
  logic        rst1_n;
  logic [3:0]  imem_ad0;
  logic [7:0]  imem_q0;
  logic [3:0]  in_d0;
  logic [3:0]  out_q0;
  logic        out_vld0;
  logic        cflag0;
  logic [5:0]  imem_ad1;
  logic [11:0] imem_q1;
  logic [7:0]  in_d1;
  logic [7:0]  out_q1;
  logic        out_vld1;
  logic        cflag1;

  logic [7:0]  rom0[16];
  logic [11:0] rom1[64];
  logic [7:0]  exp0_q[$];
  logic [7:0]  exp1_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  assign imem_q0 = rom0[imem_ad0];
  assign imem_q1 = rom1[imem_ad1];

  pipe_accum_cpu #(.DW(4), .AW(4)) dut0 (
    .CK(ck), .RST_N(rst0_n), .IMEM_AD(imem_ad0), .IMEM_Q(imem_q0), .IN_D(in_d0),
    .OUT_Q(out_q0), .OUT_VLD(out_vld0), .CFLAG(cflag0)
  );

  pipe_accum_cpu #(.DW(8), .AW(6)) dut1 (
    .CK(ck), .RST_N(rst1_n), .IMEM_AD(imem_ad1), .IMEM_Q(imem_q1), .IN_D(in_d1),
    .OUT_Q(out_q1), .OUT_VLD(out_vld1), .CFLAG(cflag1)
  );

  // clock / reset
  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Return 2 time units after the n-th following rising edge.
  task automatic wait_edges(input int n);
    repeat (n) @(posedge ck);
    #2;
  endtask

  task automatic fill_nop0();
    for (int i = 0; i < 16; i++) rom0[i] = 8'h80;
  endtask

  task automatic reset0();
    rst0_n = 1'b0;
    exp0_q.delete();
    wait_edges(3);
  endtask

  // scoreboard monitors
  always @(negedge ck) begin
    if (out_vld0) begin
      if (exp0_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL out0_unexpected: got %0h expected none", out_q0);
      end else begin
        check("out0", {28'd0, out_q0}, {24'd0, exp0_q.pop_front()});
      end
    end
    if (out_vld1) begin
      if (exp1_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL out1_unexpected: got %0h expected none", out_q1);
      end else begin
        check("out1", {24'd0, out_q1}, {24'd0, exp1_q.pop_front()});
      end
    end
  end

  initial begin
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    in_d0  = 4'd0;
    in_d1  = 8'd0;
    for (int i = 0; i < 64; i++) rom1[i] = 12'h800;
    fill_nop0();

    // reset values, first fetches and natural PC wrap
    reset0();
    check("rst_pc", {28'd0, imem_ad0}, 32'd0);
    check("rst_out", {28'd0, out_q0}, 32'd0);
    check("rst_vld", {31'd0, out_vld0}, 32'd0);
    check("rst_c", {31'd0, cflag0}, 32'd0);
    rst0_n = 1'b1;
    #1 check("pc_e0", {28'd0, imem_ad0}, 32'd0);
    wait_edges(1);
    check("pc_e1", {28'd0, imem_ad0}, 32'd1);
    wait_edges(1);
    check("pc_e2", {28'd0, imem_ad0}, 32'd2);
    wait_edges(13);
    check("pc_e15", {28'd0, imem_ad0}, 32'd15);
    wait_edges(1);
    check("pc_wrap", {28'd0, imem_ad0}, 32'd0);

    // back-to-back dependency and OUT_VLD timing
    reset0();
    fill_nop0();
    rom0[0] = 8'h33;  // MOV A,3
    rom0[1] = 8'h04;  // ADD A,4
    rom0[2] = 8'h40;  // MOV B,A
    rom0[3] = 8'h90;  // OUT B
    rom0[6] = 8'hF6;  // JMP 6
    exp0_q.push_back(8'd7);
    rst0_n = 1'b1;
    wait_edges(5);
    check("vld_before", {31'd0, out_vld0}, 32'd0);
    wait_edges(1);
    check("vld_pulse", {31'd0, out_vld0}, 32'd1);
    check("out_7", {28'd0, out_q0}, 32'd7);
    wait_edges(1);
    check("vld_after", {31'd0, out_vld0}, 32'd0);
    wait_edges(4);
    check("t2_drain", exp0_q.size(), 32'd0);

    // carry and JNC not-taken / taken
    reset0();
    fill_nop0();
    rom0[0]  = 8'h3F;  // MOV A,15
    rom0[1]  = 8'h01;  // ADD A,1
    rom0[2]  = 8'hE9;  // JNC 9 (not taken)
    rom0[3]  = 8'hB1;  // OUT 1
    rom0[4]  = 8'h01;  // ADD A,1
    rom0[5]  = 8'hE9;  // JNC 9 (taken)
    rom0[6]  = 8'hB6;
    rom0[7]  = 8'hB7;
    rom0[8]  = 8'hB8;
    rom0[9]  = 8'hB9;  // OUT 9
    rom0[10] = 8'h40;  // MOV B,A
    rom0[11] = 8'h90;  // OUT B
    rom0[12] = 8'hFC;  // JMP 12
    exp0_q.push_back(8'd1);
    exp0_q.push_back(8'd9);
    exp0_q.push_back(8'd1);
    rst0_n = 1'b1;
    wait_edges(4);
    check("c_set", {31'd0, cflag0}, 32'd1);
    wait_edges(1);
    check("c_jnc_clr", {31'd0, cflag0}, 32'd0);
    wait_edges(3);
    check("jnc_target", {28'd0, imem_ad0}, 32'd9);
    wait_edges(8);
    check("t3_drain", exp0_q.size(), 32'd0);

    // JMP at 15 squashes the wrapped fetches, then mid-run reset
    reset0();
    fill_nop0();
    rom0[0]  = 8'hB3;
    rom0[1]  = 8'hB4;
    rom0[15] = 8'hF0;  // JMP 0
    exp0_q.push_back(8'd3);
    exp0_q.push_back(8'd4);
    exp0_q.push_back(8'd3);
    exp0_q.push_back(8'd4);
    rst0_n = 1'b1;
    wait_edges(18);
    check("jmp_pc", {28'd0, imem_ad0}, 32'd0);
    wait_edges(1);
    check("squash_a", {31'd0, out_vld0}, 32'd0);
    wait_edges(1);
    check("squash_b", {31'd0, out_vld0}, 32'd0);
    wait_edges(1);
    check("resume_vld", {31'd0, out_vld0}, 32'd1);
    check("resume_out", {28'd0, out_q0}, 32'd3);
    wait_edges(2);
    check("t4_drain", exp0_q.size(), 32'd0);
    check("pre_rst_out", {28'd0, out_q0}, 32'd4);
    check("pre_rst_pc", {28'd0, imem_ad0}, 32'd5);
    rst0_n = 1'b0;
    #1;
    check("mid_rst_out", {28'd0, out_q0}, 32'd0);
    check("mid_rst_pc", {28'd0, imem_ad0}, 32'd0);
    check("mid_rst_vld", {31'd0, out_vld0}, 32'd0);

    // IN sampled in the EX cycle, carry from ADD, B-side opcodes
    reset0();
    fill_nop0();
    rom0[0]  = 8'h20;  // IN A
    rom0[1]  = 8'hB0;  // OUT 0
    rom0[2]  = 8'h06;  // ADD A,6
    rom0[3]  = 8'h40;  // MOV B,A
    rom0[4]  = 8'h90;  // OUT B
    rom0[5]  = 8'h07;  // ADD A,7
    rom0[6]  = 8'h40;  // MOV B,A
    rom0[7]  = 8'h90;  // OUT B
    rom0[8]  = 8'h60;  // IN B
    rom0[9]  = 8'h5E;  // ADD B,14
    rom0[10] = 8'h10;  // MOV A,B
    rom0[11] = 8'h70;  // MOV B,0
    rom0[12] = 8'h40;  // MOV B,A
    rom0[13] = 8'h90;  // OUT B
    rom0[14] = 8'hFE;  // JMP 14
    exp0_q.push_back(8'd0);
    exp0_q.push_back(8'd0);
    exp0_q.push_back(8'd7);
    exp0_q.push_back(8'd1);
    in_d0 = 4'd5;
    rst0_n = 1'b1;
    wait_edges(2);
    in_d0 = 4'hA;
    wait_edges(1);
    in_d0 = 4'd3;
    wait_edges(2);
    check("in_add_c", {31'd0, cflag0}, 32'd1);
    wait_edges(13);
    check("t5_drain", exp0_q.size(), 32'd0);
    rst0_n = 1'b0;

    // wide instance: 8-bit carry and 6-bit PC wrap via JMP 63
    rom1[0]  = 12'h3C8;  // MOV A,200
    rom1[1]  = 12'h064;  // ADD A,100
    rom1[2]  = 12'h400;  // MOV B,A
    rom1[3]  = 12'h900;  // OUT B
    rom1[4]  = 12'hF3F;  // JMP 63
    rom1[63] = 12'hB55;  // OUT 0x55
    exp1_q.push_back(8'd44);
    exp1_q.push_back(8'h55);
    exp1_q.push_back(8'd44);
    wait_edges(1);
    rst1_n = 1'b1;
    wait_edges(4);
    check("w_carry", {31'd0, cflag1}, 32'd1);
    wait_edges(3);
    check("w_jmp63", {26'd0, imem_ad1}, 32'd63);
    wait_edges(1);
    check("w_wrap", {26'd0, imem_ad1}, 32'd0);
    wait_edges(8);
    check("t6_drain", exp1_q.size(), 32'd0);
    rst1_n = 1'b0;
    wait_edges(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
